// File: rtl/h264_nal_pkg.sv
// Shared types and constants for the H.264 Annex-B NAL framer.
package h264_nal_pkg;

    localparam int unsigned START_CODE_LEN = 4;
    localparam logic [7:0]  EPB_BYTE       = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        SC0,
        SC1,
        SC2,
        SC3,
        HDR,
        PAYLOAD,
        EPB
    } nal_state_e;

    // One FIFO slot: end-of-unit marker, byte-present flag, payload byte.
    typedef struct packed {
        logic       eom;
        logic       hasbyte;
        logic [7:0] data;
    } nal_entry_t;

    // Start code is all zeros except its final byte.
    function automatic logic [7:0] sc_byte(input int unsigned idx);
        return (idx == START_CODE_LEN - 1) ? 8'h01 : 8'h00;
    endfunction

endpackage

// File: rtl/h264_nal_fifo.sv
// Single-clock FIFO with count-based full/empty and a registered almost-full flag.
module h264_nal_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned MARGIN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             afull
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A push against a full FIFO is dropped even if a pop happens that cycle.
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign rdata      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            afull  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            afull <= ((CW'(DEPTH) - count_next) <= CW'(MARGIN));
        end
    end

endmodule

// File: rtl/h264_nalwrap.sv
// Annex-B NAL framer: start code, header byte, then payload with emulation-prevention bytes.
module h264_nalwrap #(
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] NALHDR,
    input  logic       STROBEI,
    input  logic [7:0] BYTEI,
    input  logic       DONEI,
    output logic       VALIDO,
    output logic [7:0] BYTEO,
    input  logic       READYI,
    output logic       ENDO,
    output logic       ALMOSTFULL,
    output logic       ERR
);

    import h264_nal_pkg::*;

    localparam int unsigned EW = $bits(nal_entry_t);

    nal_state_e    state;
    logic [7:0]    hdr;
    logic [1:0]    zc;
    logic          last;

    logic          push_c;
    logic          xfer_c;
    logic          can_load_c;
    logic          do_epb_c;
    logic          pop_c;
    logic [1:0]    zc_base_c;
    logic [1:0]    zc_load_c;
    logic          full;
    logic          empty;
    nal_entry_t    wentry;
    logic [EW-1:0] rdata;
    nal_entry_t    head;

    always_comb begin
        wentry.eom     = DONEI;
        wentry.hasbyte = STROBEI;
        wentry.data    = STROBEI ? BYTEI : 8'h00;
    end

    assign push_c = STROBEI || DONEI;
    assign head   = nal_entry_t'(rdata);

    h264_nal_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .WIDTH  (EW),
        .MARGIN (AFULL_MARGIN)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push_c),
        .pop   (pop_c),
        .wdata (EW'(wentry)),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .afull (ALMOSTFULL)
    );

    // The output register doubles as the presentation stage: a FIFO head is
    // consumed when it is loaded, so the zero run already includes that byte.
    always_comb begin
        xfer_c     = VALIDO && READYI;
        zc_base_c  = (state == PAYLOAD) ? zc : 2'd0;
        can_load_c = 1'b0;
        if (state == PAYLOAD) begin
            can_load_c = !last && (!VALIDO || xfer_c);
        end else if ((state == HDR) || (state == EPB)) begin
            can_load_c = xfer_c;
        end
        do_epb_c  = can_load_c && !empty && head.hasbyte &&
                    (zc_base_c == 2'd2) && (head.data <= EPB_BYTE);
        pop_c     = can_load_c && !empty && !do_epb_c;
        zc_load_c = 2'd0;
        if (head.data == 8'h00) begin
            zc_load_c = (zc_base_c == 2'd2) ? 2'd2 : zc_base_c + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            hdr    <= 8'h00;
            zc     <= 2'd0;
            last   <= 1'b0;
            VALIDO <= 1'b0;
            BYTEO  <= 8'h00;
            ENDO   <= 1'b0;
            ERR    <= 1'b0;
        end else begin
            ENDO <= 1'b0;
            if ((START && (state != IDLE)) || (push_c && full)) begin
                ERR <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (START) begin
                        state  <= SC0;
                        hdr    <= NALHDR;
                        zc     <= 2'd0;
                        VALIDO <= 1'b1;
                        BYTEO  <= sc_byte(0);
                    end
                end
                SC0: begin
                    if (xfer_c) begin
                        state <= SC1;
                        BYTEO <= sc_byte(1);
                    end
                end
                SC1: begin
                    if (xfer_c) begin
                        state <= SC2;
                        BYTEO <= sc_byte(2);
                    end
                end
                SC2: begin
                    if (xfer_c) begin
                        state <= SC3;
                        BYTEO <= sc_byte(3);
                    end
                end
                SC3: begin
                    if (xfer_c) begin
                        state <= HDR;
                        BYTEO <= hdr;
                    end
                end
                default: begin
                    if ((state == PAYLOAD) && last) begin
                        if (xfer_c) begin
                            state  <= IDLE;
                            VALIDO <= 1'b0;
                            last   <= 1'b0;
                            ENDO   <= 1'b1;
                        end
                    end else if (can_load_c) begin
                        state  <= PAYLOAD;
                        zc     <= zc_base_c;
                        VALIDO <= 1'b0;
                        if (!empty) begin
                            if (do_epb_c) begin
                                state  <= EPB;
                                zc     <= 2'd0;
                                VALIDO <= 1'b1;
                                BYTEO  <= EPB_BYTE;
                            end else if (head.hasbyte) begin
                                VALIDO <= 1'b1;
                                BYTEO  <= head.data;
                                last   <= head.eom;
                                zc     <= zc_load_c;
                            end else if (head.eom) begin
                                state <= IDLE;
                                zc    <= 2'd0;
                                ENDO  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h264_nalwrap.sv
// Scoreboard bench for h264_nalwrap: directed cases plus randomized NAL units.
module tb_h264_nalwrap;

    typedef logic [7:0] byte_q_t[$];

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] NALHDR = 8'h00;
    logic       STROBEI = 1'b0;
    logic [7:0] BYTEI = 8'h00;
    logic       DONEI = 1'b0;
    logic       READYI = 1'b0;
    logic       VALIDO;
    logic [7:0] BYTEO;
    logic       ENDO;
    logic       ALMOSTFULL;
    logic       ERR;

    int         vectors = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic       rand_ready = 1'b0;
    logic       ready_dir = 1'b1;

    h264_nalwrap #(.FIFO_DEPTH(16), .AFULL_MARGIN(4)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .NALHDR     (NALHDR),
        .STROBEI    (STROBEI),
        .BYTEI      (BYTEI),
        .DONEI      (DONEI),
        .VALIDO     (VALIDO),
        .BYTEO      (BYTEO),
        .READYI     (READYI),
        .ENDO       (ENDO),
        .ALMOSTFULL (ALMOSTFULL),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    always begin
        @(posedge CLK);
        #2;
        READYI = rand_ready ? ($urandom_range(0, 3) != 0) : ready_dir;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d outputs pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: Annex-B framing from the rule "after two zero bytes, a byte <= 3 gets an 0x03 first".
    function automatic void expect_unit(input logic [7:0] h, input byte_q_t pl, input bit with_end);
        int zeros = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back(9'h000);
        exp_q.push_back(9'h001);
        exp_q.push_back({1'b0, h});
        foreach (pl[i]) begin
            if (zeros >= 2 && pl[i] <= 8'h03) begin
                exp_q.push_back(9'h003);
                zeros = 0;
            end
            exp_q.push_back({1'b0, pl[i]});
            zeros = (pl[i] == 8'h00) ? zeros + 1 : 0;
        end
        if (with_end) exp_q.push_back(9'h100);
    endfunction

    function automatic byte_q_t bytes_of(input logic [63:0] v, input int n);
        byte_q_t q;
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i*8 +: 8]);
        return q;
    endfunction

    // Monitor: every transfer and every ENDO consumes one scoreboard entry.
    logic       stall = 1'b0;
    logic [7:0] held = 8'h00;
    logic [8:0] e;
    always @(negedge CLK) begin
        if (RESET) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("stall_valid", 32'(VALIDO), 32'd1);
                check("stall_byte", 32'(BYTEO), 32'(held));
            end
            if (VALIDO && READYI) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL out_byte: got 0x%0h, expected nothing", BYTEO);
                end else begin
                    e = exp_q.pop_front();
                    check("out_byte", 32'({1'b0, BYTEO}), 32'(e));
                end
            end
            if (ENDO) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL endo: got ENDO, expected nothing");
                end else begin
                    e = exp_q.pop_front();
                    check("endo", 32'h100, 32'(e));
                end
            end
            stall = VALIDO && !READYI;
            held  = BYTEO;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        exp_q.delete();
        repeat (n) tick();
        RESET = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] h);
        START  = 1'b1;
        NALHDR = h;
        tick();
        START  = 1'b0;
    endtask

    task automatic push_raw(input logic [7:0] b, input logic done);
        STROBEI = 1'b1;
        BYTEI   = b;
        DONEI   = done;
        tick();
        STROBEI = 1'b0;
        DONEI   = 1'b0;
    endtask

    task automatic push_thr(input logic [7:0] b, input logic done);
        int n = 0;
        while (ALMOSTFULL && n < 2000) begin
            tick();
            n++;
        end
        push_raw(b, done);
    endtask

    task automatic done_only();
        DONEI = 1'b1;
        tick();
        DONEI = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_unit(input logic [7:0] h, input logic [63:0] v, input int n);
        byte_q_t pl;
        pl = bytes_of(v, n);
        expect_unit(h, pl, 1'b1);
        do_start(h);
        for (int i = 0; i < n; i++) push_raw(pl[i], (i == n - 1));
        if (n == 0) done_only();
        wait_drain("unit_drain", 200);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 7);
        if (r < 4) return 8'h00;
        if (r < 6) return 8'($urandom_range(1, 3));
        return 8'($urandom);
    endfunction

    initial begin
        byte_q_t pl;
        int      len;
        int      pre;
        bit      tog;
        logic [7:0] h;

        // Reset values
        repeat (3) tick();
        check("rst_valid", 32'(VALIDO), 32'd0);
        check("rst_byte", 32'(BYTEO), 32'd0);
        check("rst_endo", 32'(ENDO), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_afull", 32'(ALMOSTFULL), 32'd0);
        RESET = 1'b0;
        tick();
        tick();

        // Basic frame with first-byte latency
        pl = bytes_of(64'h8884, 2);
        expect_unit(8'h65, pl, 1'b1);
        do_start(8'h65);
        check("start_lat_valid", 32'(VALIDO), 32'd1);
        check("start_lat_byte", 32'(BYTEO), 32'h00);
        push_raw(8'h88, 1'b0);
        push_raw(8'h84, 1'b1);
        wait_drain("basic_drain", 100);

        // Emulation prevention cases, including a zero header byte
        run_unit(8'h41, 64'h000001, 3);
        run_unit(8'h41, 64'h00000000, 4);
        run_unit(8'h41, 64'h000004, 3);
        run_unit(8'h00, 64'h0001, 2);
        run_unit(8'h21, 64'h0000, 2);
        run_unit(8'h06, 64'h0, 0);

        // Randomized units under random sink backpressure
        rand_ready = 1'b1;
        for (int u = 0; u < 40; u++) begin
            pl.delete();
            len = $urandom_range(0, 12);
            h   = 8'($urandom);
            tog = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < len; i++) pl.push_back(rand_byte());
            pre = 0;
            if (len > 1) pre = $urandom_range(0, (len - 1 < 3) ? len - 1 : 3);
            for (int i = 0; i < pre; i++) push_thr(pl[i], 1'b0);
            wait_drain("rand_drain", 3000);
            expect_unit(h, pl, 1'b1);
            do_start(h);
            for (int i = pre; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                push_thr(pl[i], (i == len - 1) && tog);
            end
            if (!tog || len == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                done_only();
            end
        end
        wait_drain("rand_final", 3000);
        rand_ready = 1'b0;
        ready_dir  = 1'b1;
        tick();
        tick();
        check("rand_err", 32'(ERR), 32'd0);

        // Marker-only end; START during payload flags an error and is ignored
        pl = bytes_of(64'h1122, 2);
        expect_unit(8'h01, pl, 1'b1);
        do_start(8'h01);
        push_raw(8'h11, 1'b0);
        push_raw(8'h22, 1'b0);
        for (int n = 0; n < 50 && exp_q.size() > 1; n++) tick();
        check("err_before_start", 32'(ERR), 32'd0);
        START  = 1'b1;
        NALHDR = 8'h99;
        tick();
        START  = 1'b0;
        check("err_misplaced_start", 32'(ERR), 32'd1);
        tick();
        done_only();
        wait_drain("marker_drain", 100);

        // Overflow with stalled sink
        do_reset(1);
        ready_dir = 1'b0;
        tick();
        tick();
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'hA0 + 8'(i));
        expect_unit(8'h65, pl, 1'b1);
        do_start(8'h65);
        for (int i = 0; i < 17; i++) begin
            push_raw(8'hA0 + 8'(i), 1'b0);
            if (i == 10) check("afull_after_11", 32'(ALMOSTFULL), 32'd0);
            if (i == 11) check("afull_after_12", 32'(ALMOSTFULL), 32'd1);
            if (i == 15) check("err_at_full", 32'(ERR), 32'd0);
        end
        check("err_overflow", 32'(ERR), 32'd1);
        check("stalled_first_byte", 32'(BYTEO), 32'h00);
        ready_dir = 1'b1;
        repeat (8) tick();
        done_only();
        wait_drain("overflow_drain", 200);

        // Reset mid-payload flushes the FIFO and the held output byte
        do_reset(1);
        tick();
        pl = bytes_of(64'h10, 1);
        expect_unit(8'h65, pl, 1'b0);
        do_start(8'h65);
        push_raw(8'h10, 1'b0);
        wait_drain("mid_drain", 100);
        ready_dir = 1'b0;
        tick();
        tick();
        push_raw(8'h99, 1'b0);
        push_raw(8'h98, 1'b0);
        tick();
        check("mid_held_valid", 32'(VALIDO), 32'd1);
        RESET = 1'b1;
        exp_q.delete();
        tick();
        check("mid_rst_valid", 32'(VALIDO), 32'd0);
        check("mid_rst_byte", 32'(BYTEO), 32'd0);
        check("mid_rst_endo", 32'(ENDO), 32'd0);
        check("mid_rst_afull", 32'(ALMOSTFULL), 32'd0);
        RESET     = 1'b0;
        ready_dir = 1'b1;
        tick();
        tick();
        run_unit(8'h41, 64'h000002, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/h264_nalwrap.md
# h264_nalwrap

NAL-unit framer directly downstream of the byte packer in the H.264 encoder. It consumes the packed bitstream byte strobes and the end-of-stream pulse, and emits an Annex-B byte stream on a valid/ready interface:
- start code 00 00 00 01;
- NAL header byte;
- payload with emulation-prevention bytes (0x03) inserted.

A small FIFO absorbs the non-stallable input while the framer inserts extra bytes or the sink stalls.

## Interface
- FIFO_DEPTH, 16, entries in input FIFO; power of two, ≥8.
- AFULL_MARGIN, 4, ALMOSTFULL asserts when free entries ≤ this.

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high.
- START  in  1  pulse: begin a NAL unit; NALHDR is sampled on this cycle.
- NALHDR  in  8  NAL header byte, e.g. 0x65 for an IDR slice.
- STROBEI  in  1  input byte valid; no backpressure.
- BYTEI  in  8  input byte.
- DONEI  in  1  pulse: end of payload; may coincide with STROBEI, in which case that byte is the last one.
- VALIDO  out  1  output byte valid.
- BYTEO  out  8  output byte.
- READYI  in  1  sink ready.
- ENDO  out  1  one-cycle pulse: NAL unit complete.
- ALMOSTFULL  out  1  FIFO free entries ≤ AFULL_MARGIN; feeds upstream throttling.
- ERR  out  1  sticky: overflow or misplaced START; cleared only by RESET.

## Operation
- FIFO entry is 10 bits:
  - [9] = end marker;
  - [8] = has byte;
  - [7:0] = byte.
- Push rules:
  - STROBEI pushes {DONEI, 1, BYTEI}.
  - DONEI without STROBEI pushes {1, 0, 8'h00}.
  - Push with FIFO full: the entry is dropped and ERR is set. A pop on the same cycle does not rescue the push (the full decision is count-based).
- FSM states: IDLE, SC0, SC1, SC2, SC3, HDR, PAYLOAD, EPB.
  - IDLE + START → SC0; latch NALHDR; zero counter zc := 0.
  - SC0/SC1/SC2 present 0x00; SC3 presents 0x01; HDR presents the latched header. Each state advances on transfer (VALIDO && READYI).
  - HDR transfer → PAYLOAD, zc := 0.
  - PAYLOAD, FIFO non-empty, head has byte b:
    - if zc==2 and b ≤ 0x03 → EPB, which presents 0x03; on transfer zc := 0 and return to PAYLOAD without popping.
    - otherwise present b; on transfer pop, and zc := (b==0) ? min(zc+1, 2) : 0.
  - Head entry with [9]=1: after its byte (if any) transfers, pop, pulse ENDO and go to IDLE.
  - Head entry with [8]=0: pop without output; if [9]=1, ENDO and IDLE.
- START outside IDLE is ignored and sets ERR. Payload bytes arriving before or during the start code are buffered, not lost.
- Bytes of the next NAL unit may already sit in the FIFO when ENDO fires; they are held until the next START.

## Timing
- Reset values:
  - VALIDO=0, BYTEO=0, ENDO=0, ALMOSTFULL=0, ERR=0;
  - FSM=IDLE, FIFO empty, zc=0.
- Output handshake:
  - VALIDO and BYTEO are registered.
  - Once VALIDO=1, BYTEO is held stable until READYI=1.
  - VALIDO never drops without a transfer, except on RESET.
- START → first 0x00 on VALIDO: 1 cycle.
- With READYI held high, one byte per cycle: START at cycle t gives bytes at t+1..t+5.
- Push at cycle t is poppable at t+1. Latency STROBEI → VALIDO in PAYLOAD with the FIFO empty and READYI high: 2 cycles.
- ENDO is asserted the cycle after the final transfer or marker pop; IDLE accepts START on that same cycle.
- ALMOSTFULL is registered and reflects the occupancy after this cycle's push and pop.
- RESET mid-operation: FIFO flushed, partial NAL unit discarded, all outputs to their reset values the next cycle.

## Structure
- Package h264_nal_pkg holds:
  - the state enum;
  - constants START_CODE_LEN=4 and EPB_BYTE=8'h03;
  - the 10-bit FIFO entry struct (end, hasbyte, data).
- Sub-module h264_nal_fifo: single-clock synchronous FIFO with count, full, empty and almostfull; parameterised by depth and width.
- The FSM, zero counter and output register live in h264_nalwrap.

## Test plan
- Reset: hold RESET 3 cycles → VALIDO=0, BYTEO=0, ENDO=0, ERR=0, ALMOSTFULL=0.
- Basic frame: START with NALHDR=0x65, bytes 0x88, 0x84 (DONEI on 0x84), READYI=1 → output 00 00 00 01 65 88 84; ENDO one cycle after 0x84.
- Emulation prevention:
  - payload 00 00 01 → 00 00 03 01;
  - payload 00 00 00 00 → 00 00 03 00 00;
  - payload 00 00 04 → unchanged;
  - header byte does not count toward zc.
- Stall/overflow: READYI=0, START, push 17 bytes with FIFO_DEPTH=16 → ALMOSTFULL high after the 12th push; 17th byte dropped; ERR=1. Release READYI → the first 16 bytes appear intact and BYTEO is stable while stalled.
- Marker-only end: bytes 0x11, 0x22, then DONEI alone 3 cycles later → output …11 22; ENDO follows; a START during PAYLOAD sets ERR and is ignored.
- Reset mid-payload after 00 00 00 01 65 0x10 → FIFO empty; next START produces a clean start code with zc=0.
